shift_unit_arbiter: RTL and testbench

// - Shares one combinational barrel_shifter instance between NUM_REQ requesters (e.g. ALU issue, AMO/CSR helper).
// - Per requester: valid/ready request port. Round-robin grant.
// - Drives the shifter control inputs and registers the shifter result into a one-entry output slot tagged with requester index and ID.
// - Sits between issue logic and writeback in the pipeline.

---
 rtl/shift_unit_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_shift_unit_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter that shares one external combinational barrel shifter between
// NUM_REQ requesters and holds results in a one-entry output slot.
// Define SHIFT_ROTATE_EN to run op 11 as a two-pass rotate right; otherwise op 11 runs as SRL.
module shift_unit_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3,
  parameter int XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*XLEN-1:0]    req_data,
  input  logic [NUM_REQ*5-1:0]       req_amt,
  input  logic [NUM_REQ*2-1:0]       req_op,
  input  logic [NUM_REQ*ID_W-1:0]    req_id,
  output logic [XLEN-1:0]            sh_input,
  output logic [4:0]                 sh_amount,
  output logic                       sh_arith,
  output logic                       sh_lshift,
  input  logic [XLEN-1:0]            sh_result,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [XLEN-1:0]            res_data,
  output logic [$clog2(NUM_REQ)-1:0] res_src,
  output logic [ID_W-1:0]            res_id
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic             resValid_q, resValid_d;
  logic [XLEN-1:0]  resData_q, resData_d;
  logic [SRC_W-1:0] resSrc_q, resSrc_d;
  logic [ID_W-1:0]  resId_q, resId_d;
  logic [SRC_W-1:0] rrPtr_q, rrPtr_d;

  logic             slotFree;
  logic             idle;
  logic             grantValid;
  logic [SRC_W-1:0] grantIdx;
  logic [SRC_W-1:0] cand;
  logic [XLEN-1:0]  gData;
  logic [4:0]       gAmt;
  logic [1:0]       gOp;
  logic [ID_W-1:0]  gId;
  logic             grantRor;

`ifdef SHIFT_ROTATE_EN
  typedef enum logic {IDLE, ROT2} state_t;
  state_t           state_q, state_d;
  logic [XLEN-1:0]  rotPartial_q, rotPartial_d;
  logic [XLEN-1:0]  rotOperand_q, rotOperand_d;
  logic [4:0]       rotAmt_q, rotAmt_d;
  logic [SRC_W-1:0] rotSrc_q, rotSrc_d;
  logic [ID_W-1:0]  rotId_q, rotId_d;

  assign idle     = (state_q == IDLE);
  assign grantRor = (gOp == 2'b11);
`else
  assign idle     = 1'b1;
  assign grantRor = 1'b0;
`endif

  assign slotFree  = !resValid_q || res_ready;
  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_src   = resSrc_q;
  assign res_id    = resId_q;

  // First valid requester at or after rrPtr_q, searched cyclically.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    if (idle && slotFree && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = SRC_W'((int'(rrPtr_q) + k) % NUM_REQ);
        if (!grantValid && req_valid[cand]) begin
          grantValid = 1'b1;
          grantIdx   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    gData     = '0;
    gAmt      = '0;
    gOp       = '0;
    gId       = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grantIdx == SRC_W'(r)) begin
        req_ready[r] = grantValid;
        gData        = req_data[r*XLEN +: XLEN];
        gAmt         = req_amt[r*5 +: 5];
        gOp          = req_op[r*2 +: 2];
        gId          = req_id[r*ID_W +: ID_W];
      end
    end
  end

  // The second rotate pass shifts left by (32-amt)&31, which is just -amt in 5 bits.
  always_comb begin
    sh_input  = '0;
    sh_amount = '0;
    sh_arith  = 1'b0;
    sh_lshift = 1'b0;
`ifdef SHIFT_ROTATE_EN
    if (state_q == ROT2) begin
      sh_input  = rotOperand_q;
      sh_amount = 5'd0 - rotAmt_q;
      sh_lshift = 1'b1;
    end else
`endif
    if (grantValid) begin
      sh_input  = gData;
      sh_amount = gAmt;
      case (gOp)
        2'b01:   sh_arith  = gData[XLEN-1];
        2'b10:   sh_lshift = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    resValid_d = resValid_q && !res_ready;
    resData_d  = resData_q;
    resSrc_d   = resSrc_q;
    resId_d    = resId_q;
    rrPtr_d    = rrPtr_q;
`ifdef SHIFT_ROTATE_EN
    state_d      = state_q;
    rotPartial_d = rotPartial_q;
    rotOperand_d = rotOperand_q;
    rotAmt_d     = rotAmt_q;
    rotSrc_d     = rotSrc_q;
    rotId_d      = rotId_q;
`endif
    if (grantValid) begin
      rrPtr_d = (grantIdx == SRC_W'(NUM_REQ - 1)) ? '0 : grantIdx + SRC_W'(1);
      if (!grantRor) begin
        resValid_d = 1'b1;
        resData_d  = sh_result;
        resSrc_d   = grantIdx;
        resId_d    = gId;
      end
`ifdef SHIFT_ROTATE_EN
      else begin
        state_d      = ROT2;
        rotPartial_d = sh_result;
        rotOperand_d = gData;
        rotAmt_d     = gAmt;
        rotSrc_d     = grantIdx;
        rotId_d      = gId;
      end
`endif
    end
`ifdef SHIFT_ROTATE_EN
    if (state_q == ROT2 && slotFree) begin
      resValid_d = 1'b1;
      resData_d  = rotPartial_q | sh_result;
      resSrc_d   = rotSrc_q;
      resId_d    = rotId_q;
      state_d    = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resSrc_q   <= '0;
      resId_q    <= '0;
      rrPtr_q    <= '0;
`ifdef SHIFT_ROTATE_EN
      state_q      <= IDLE;
      rotPartial_q <= '0;
      rotOperand_q <= '0;
      rotAmt_q     <= '0;
      rotSrc_q     <= '0;
      rotId_q      <= '0;
`endif
    end else begin
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
      resSrc_q   <= resSrc_d;
      resId_q    <= resId_d;
      rrPtr_q    <= rrPtr_d;
`ifdef SHIFT_ROTATE_EN
      state_q      <= state_d;
      rotPartial_q <= rotPartial_d;
      rotOperand_q <= rotOperand_d;
      rotAmt_q     <= rotAmt_d;
      rotSrc_q     <= rotSrc_d;
      rotId_q      <= rotId_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Table-driven bench for shift_unit_arbiter with two requesters and a behavioural barrel shifter.
// Rotate expectations follow SHIFT_ROTATE_EN, matching the build of the design.
module tb_shift_unit_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 3;
  localparam int XLEN    = 32;
  localparam logic [1:0] SRL = 2'b00, SRA = 2'b01, SLL = 2'b10, ROR = 2'b11;
  localparam int NV = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [31:0]       data0, data1;
  logic [4:0]        amt0, amt1;
  logic [1:0]        op0, op1;
  logic [2:0]        id0, id1;
  logic [XLEN-1:0]   sh_input;
  logic [4:0]        sh_amount;
  logic              sh_arith;
  logic              sh_lshift;
  logic [XLEN-1:0]   sh_result;
  logic              res_valid;
  logic              res_ready;
  logic [XLEN-1:0]   res_data;
  logic              res_src;
  logic [ID_W-1:0]   res_id;
  logic [63:0]       wide;

  shift_unit_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data({data1, data0}), .req_amt({amt1, amt0}),
    .req_op({op1, op0}), .req_id({id1, id0}),
    .sh_input(sh_input), .sh_amount(sh_amount), .sh_arith(sh_arith), .sh_lshift(sh_lshift),
    .sh_result(sh_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_id(res_id)
  );

  // Behavioural barrel shifter: arith supplies the fill bit for right shifts.
  always_comb begin
    wide = {{32{sh_arith}}, sh_input} >> sh_amount;
    sh_result = sh_lshift ? (sh_input << sh_amount) : wide[31:0];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] d0; logic [4:0] a0; logic [1:0] o0; logic [2:0] i0;
    logic [31:0] d1; logic [4:0] a1; logic [1:0] o1; logic [2:0] i1;
    logic        resReady;
    logic [1:0]  expReady;
    logic        expValid;
    logic [31:0] expData;
    logic        expSrc;
    logic [2:0]  expId;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mkVec(
    input logic [1:0] valid,
    input logic [31:0] d0, input logic [4:0] a0, input logic [1:0] o0, input logic [2:0] i0,
    input logic [31:0] d1, input logic [4:0] a1, input logic [1:0] o1, input logic [2:0] i1,
    input logic resReady, input logic [1:0] expReady, input logic expValid,
    input logic [31:0] expData, input logic expSrc, input logic [2:0] expId);
    vec_t v;
    v.valid = valid;
    v.d0 = d0; v.a0 = a0; v.o0 = o0; v.i0 = i0;
    v.d1 = d1; v.a1 = a1; v.o1 = o1; v.i1 = i1;
    v.resReady = resReady; v.expReady = expReady; v.expValid = expValid;
    v.expData = expData; v.expSrc = expSrc; v.expId = expId;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req_valid = v.valid;
    data0 = v.d0; amt0 = v.a0; op0 = v.o0; id0 = v.i0;
    data1 = v.d1; amt1 = v.a1; op1 = v.o1; id1 = v.i1;
    res_ready = v.resReady;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idleCycle(input logic rdy);
    @(negedge clk);
    applyStimulus(mkVec(2'b00, 0, 0, SRL, 0, 0, 0, SRL, 0, rdy, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

  // Issues op 11 from requester 0 and checks latency, the second-pass drive and the result.
  task automatic runRor(input logic [4:0] amt, input logic [4:0] expRotAmt,
                        input logic [31:0] expData, input string tag);
    @(negedge clk);
    applyStimulus(mkVec(2'b01, 32'hF1, amt, ROR, 3'd3, 0, 0, SRL, 0, 1'b1, 0, 0, 0, 0, 0));
    #1 checkOutput({tag, " ready"}, 32'(req_ready), 32'h1);
    @(posedge clk); #1;
`ifdef SHIFT_ROTATE_EN
    checkOutput({tag, " rot2 valid"}, 32'(res_valid), 32'h0);
    @(negedge clk);
    applyStimulus(mkVec(2'b10, 0, 0, SRL, 0, 32'h5, 5'd1, SLL, 3'd1, 1'b1, 0, 0, 0, 0, 0));
    #1 checkOutput({tag, " rot2 no grant"}, 32'(req_ready), 32'h0);
    checkOutput({tag, " rot2 amount"}, 32'(sh_amount), 32'(expRotAmt));
    checkOutput({tag, " rot2 lshift"}, 32'(sh_lshift), 32'h1);
    @(posedge clk); #1;
`endif
    checkOutput({tag, " valid"}, 32'(res_valid), 32'h1);
    checkOutput({tag, " data"}, res_data, expData);
    checkOutput({tag, " src"}, 32'(res_src), 32'h0);
    checkOutput({tag, " id"}, 32'(res_id), 32'h3);
    idleCycle(1'b1);
  endtask

  initial begin
    // Fairness, backpressure and operand boundaries; rr pointer tracked by hand in the comments.
    vecs[0]  = mkVec(2'b01, 32'h1, 5'd4, SLL, 3'd5, 0, 0, SRL, 0, 1, 2'b01, 1, 32'h10, 0, 3'd5);
    vecs[1]  = mkVec(2'b10, 0, 0, SRL, 0, 32'h8000_0000, 5'd31, SRA, 3'd2, 1, 2'b10, 1, 32'hFFFF_FFFF, 1, 3'd2);
    vecs[2]  = mkVec(2'b10, 0, 0, SRL, 0, 32'h8000_0000, 5'd31, SRL, 3'd3, 1, 2'b10, 1, 32'h1, 1, 3'd3);
    vecs[3]  = mkVec(2'b11, 32'hF0, 5'd4, SRL, 3'd1, 32'h3, 5'd2, SLL, 3'd6, 1, 2'b01, 1, 32'hF, 0, 3'd1);
    vecs[4]  = mkVec(2'b11, 32'hF0, 5'd4, SRL, 3'd1, 32'h3, 5'd2, SLL, 3'd6, 1, 2'b10, 1, 32'hC, 1, 3'd6);
    vecs[5]  = mkVec(2'b11, 32'hF0, 5'd4, SRL, 3'd1, 32'h3, 5'd2, SLL, 3'd6, 1, 2'b01, 1, 32'hF, 0, 3'd1);
    vecs[6]  = mkVec(2'b11, 32'hF0, 5'd4, SRL, 3'd1, 32'h3, 5'd2, SLL, 3'd6, 1, 2'b10, 1, 32'hC, 1, 3'd6);
    vecs[7]  = mkVec(2'b11, 32'hF0, 5'd4, SRL, 3'd1, 32'h3, 5'd2, SLL, 3'd6, 0, 2'b00, 1, 32'hC, 1, 3'd6);
    vecs[8]  = mkVec(2'b11, 32'hF0, 5'd4, SRL, 3'd1, 32'h3, 5'd2, SLL, 3'd6, 0, 2'b00, 1, 32'hC, 1, 3'd6);
    vecs[9]  = mkVec(2'b11, 32'hF0, 5'd4, SRL, 3'd1, 32'h3, 5'd2, SLL, 3'd6, 1, 2'b01, 1, 32'hF, 0, 3'd1);
    vecs[10] = mkVec(2'b00, 0, 0, SRL, 0, 0, 0, SRL, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[11] = mkVec(2'b01, 32'h4000_0000, 5'd2, SRA, 3'd7, 0, 0, SRL, 0, 1, 2'b01, 1, 32'h1000_0000, 0, 3'd7);
    vecs[12] = mkVec(2'b10, 0, 0, SRL, 0, 32'hDEAD_BEEF, 5'd0, SLL, 3'd4, 1, 2'b10, 1, 32'hDEAD_BEEF, 1, 3'd4);
    vecs[13] = mkVec(2'b00, 0, 0, SRL, 0, 0, 0, SRL, 0, 1, 2'b00, 0, 0, 0, 0);
    vecs[14] = mkVec(2'b01, 32'h8000_0000, 5'd1, SRL, 3'd0, 0, 0, SRL, 0, 0, 2'b01, 1, 32'h4000_0000, 0, 3'd0);
    vecs[15] = mkVec(2'b10, 0, 0, SRL, 0, 32'h5, 5'd1, SLL, 3'd1, 0, 2'b00, 1, 32'h4000_0000, 0, 3'd0);
    vecs[16] = mkVec(2'b00, 0, 0, SRL, 0, 0, 0, SRL, 0, 1, 2'b00, 0, 0, 0, 0);

    rst = 1'b1;
    applyStimulus(mkVec(2'b11, 32'h1, 5'd1, SLL, 3'd1, 32'h2, 5'd1, SLL, 3'd2, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", 32'(req_ready), 32'h0);
    checkOutput("reset valid", 32'(res_valid), 32'h0);
    checkOutput("reset data", res_data, 32'h0);
    checkOutput("reset src", 32'(res_src), 32'h0);
    checkOutput("reset id", 32'(res_id), 32'h0);
    rst = 1'b0;
    applyStimulus(mkVec(2'b00, 0, 0, SRL, 0, 0, 0, SRL, 0, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].expReady));
      if (vecs[i].expReady == 2'b00)
        checkOutput($sformatf("vec%0d idle drive", i),
                    32'(sh_input != 0 || sh_amount != 0 || sh_arith || sh_lshift), 32'h0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d valid", i), 32'(res_valid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d data", i), res_data, vecs[i].expData);
        checkOutput($sformatf("vec%0d src", i), 32'(res_src), 32'(vecs[i].expSrc));
        checkOutput($sformatf("vec%0d id", i), 32'(res_id), 32'(vecs[i].expId));
      end
    end

`ifdef SHIFT_ROTATE_EN
    runRor(5'd4, 5'd28, 32'h1000_000F, "ror4");
`else
    runRor(5'd4, 5'd28, 32'h0000_000F, "ror4");
`endif
    runRor(5'd0, 5'd0, 32'h0000_00F1, "ror0");

    // rrPtr is 1 here; the grant after reset must come from requester 0.
    @(negedge clk);
    applyStimulus(mkVec(2'b01, 32'h1, 5'd1, SLL, 3'd2, 0, 0, SRL, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("prerst ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    checkOutput("prerst valid", 32'(res_valid), 32'h1);
    checkOutput("prerst data", res_data, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mkVec(2'b11, 32'h1, 5'd1, SLL, 3'd2, 32'h5, 5'd1, SLL, 3'd1, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("rst ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    checkOutput("rst valid", 32'(res_valid), 32'h0);
    checkOutput("rst data", res_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    #1 checkOutput("rst rr ptr", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    checkOutput("postrst data", res_data, 32'h2);
    checkOutput("postrst src", 32'(res_src), 32'h0);

`ifdef SHIFT_ROTATE_EN
    @(negedge clk);
    applyStimulus(mkVec(2'b01, 32'hF1, 5'd4, ROR, 3'd3, 0, 0, SRL, 0, 1, 0, 0, 0, 0, 0));
    #1 checkOutput("inflight ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    checkOutput("inflight rot2", 32'(res_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mkVec(2'b00, 0, 0, SRL, 0, 0, 0, SRL, 0, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    checkOutput("inflight rst valid", 32'(res_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("inflight dropped", 32'(res_valid), 32'h0);
    @(negedge clk);
    applyStimulus(mkVec(2'b11, 32'h1, 5'd1, SLL, 3'd2, 32'h5, 5'd1, SLL, 3'd1, 1, 0, 0, 0, 0, 0));
    #1 checkOutput("inflight rr ptr", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
